// File: rtl/tmds_serdes_seq.sv
// Bring-up sequencer and word scheduler for a 3-lane 10:1 TMDS serializer bank.
// Gates serializer reset on clock lock, sends a control preamble, then streams encoder words with idle fill.
module tmds_serdes_seq #(
  parameter int          RST_CYCLES = 16,
  parameter int          PRE_CYCLES = 128,
  parameter logic [9:0]  CTRL_TOKEN = 10'b1101010100,
  parameter int          CNT_W      = 16
) (
  input  logic             pclk,
  input  logic             rst_n,
  input  logic             mmcm_locked,
  input  logic             tx_en,
  input  logic [29:0]      word_i,
  input  logic             word_vld,
  output logic             word_rdy,
  output logic [29:0]      ser_data,
  output logic             ser_rst,
  output logic             link_up,
  output logic             underflow,
  output logic [CNT_W-1:0] underflow_cnt
);

  localparam int MAX_CYC = (RST_CYCLES > PRE_CYCLES) ? RST_CYCLES : PRE_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(PRE_CYCLES - 1);
  localparam logic [29:0]   CTRL3    = {3{CTRL_TOKEN}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RST_HOLD,
    ST_PREAMBLE,
    ST_ACTIVE
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_sync1;
  logic          r_lock_s;
  logic          w_clr;
  logic          w_starved;
  logic [29:0]   w_data_nxt;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= 1'b0;
      r_lock_s <= 1'b0;
    end else begin
      r_sync1  <= mmcm_locked;
      r_lock_s <= r_sync1;
    end
  end

  // Loss of lock or enable wins over any terminal count in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_clr       = 1'b0;
    if (!(r_lock_s && tx_en)) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_RST_HOLD;
          w_cnt_nxt   = '0;
          w_clr       = 1'b1;
        end
        ST_RST_HOLD: begin
          if (r_cnt == RST_LAST) begin
            w_state_nxt = ST_PREAMBLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        ST_PREAMBLE: begin
          if (r_cnt == PRE_LAST) begin
            w_state_nxt = ST_ACTIVE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_ACTIVE;
        end
      endcase
    end
  end

  always_comb begin
    w_starved  = 1'b0;
    w_data_nxt = '0;
    case (r_state)
      ST_PREAMBLE: w_data_nxt = CTRL3;
      ST_ACTIVE: begin
        w_starved  = !word_vld;
        w_data_nxt = word_vld ? word_i : CTRL3;
      end
      default: w_data_nxt = '0;
    endcase
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      ser_rst  <= 1'b1;
      link_up  <= 1'b0;
      word_rdy <= 1'b0;
      ser_data <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      ser_rst  <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_RST_HOLD);
      link_up  <= (w_state_nxt == ST_ACTIVE);
      word_rdy <= (w_state_nxt == ST_ACTIVE);
      ser_data <= w_data_nxt;
    end
  end

  // Underflow status survives IDLE so software can read it after a link drop.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      underflow     <= 1'b0;
      underflow_cnt <= '0;
    end else if (w_clr) begin
      underflow     <= 1'b0;
      underflow_cnt <= '0;
    end else if (w_starved) begin
      underflow <= 1'b1;
      if (underflow_cnt != {CNT_W{1'b1}}) begin
        underflow_cnt <= underflow_cnt + 1'b1;
      end
    end
  end

endmodule
